alu_flags_stage: RTL and testbench
==================================

ALU_FLAGS_STAGE -- requirements
Module: alu_flags_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1: upstream 16-bit ALU (four cascaded 4-bit CLA slices) presents a result.
REQ-004 SHALL have port in_ready, output, 1: stage can accept a beat this cycle.
REQ-005 SHALL have port in_result, input, 16: combined slice result bits.
REQ-006 SHALL have port in_c_last, input, 1: carry out of the MSB slice.
REQ-007 SHALL have port in_a_msb, input, 1: operand A bit 15.
REQ-008 SHALL have port in_b_msb, input, 1: post-inversion operand B bit 15, i.e. as fed to the slice.
REQ-009 SHALL have port in_aluop, input, 3: ALUop used for the beat.
REQ-010 SHALL have port out_valid, input-side ready counterpart out_ready (input, 1), and outputs out_valid (1), out_result (16), out_zero, out_neg, out_carry, out_ovf (1 each).

Function
REQ-011 SHALL transfer a beat in when in_valid && in_ready, and out when out_valid && out_ready, both at the rising clk edge.
REQ-012 SHALL buffer beats in a 2-entry FIFO (slots head/tail) with in-order delivery.
REQ-013 SHALL drive in_ready = 1 when occupancy < 2, derived from registered state only; no combinational path from out_ready to in_ready.
REQ-014 SHALL drive out_valid = 1 when occupancy > 0; outputs come from the head slot register.
REQ-015 SHALL give latency 1: a beat accepted at edge N into an empty stage is visible on outputs after edge N.
REQ-016 SHALL, on simultaneous accept and release, keep occupancy unchanged; with occupancy 2 and out_ready=1 in the same cycle, in_ready stays 0 that cycle.
REQ-017 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-018 SHALL compute flags at capture time: zero = (in_result == 0); neg = in_result[15].
REQ-019 SHALL treat the beat as arithmetic when in_aluop[1:0] == 2'b10 (010 add, 110 sub); otherwise carry = 0 and ovf = 0.
REQ-020 SHALL, for arithmetic beats, set carry = in_c_last (sub: 1 means no borrow), and ovf = (in_a_msb == in_b_msb) && (in_result[15] != in_a_msb).
REQ-021 SHALL ignore in_* values when the beat is not accepted.

Reset
REQ-022 SHALL, while rst_n=0, clear occupancy to 0 and drive out_valid=0, in_ready=0, out_result=0, all flags 0.
REQ-023 SHALL, on reset asserted mid-transfer, discard all buffered beats; no beat is delivered after release.
REQ-024 SHALL drive in_ready=1 from the first clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL compile a sticky-overflow feature under macro ALU_FLAGS_STICKY_OVF_EN.
REQ-026 SHALL, with ALU_FLAGS_STICKY_OVF_EN defined, add input ovf_clr (1) and output sticky_ovf (1); sticky_ovf sets on output handshake of a beat with ovf=1, clears on ovf_clr=1 (ovf_clr wins over set in the same cycle), and resets to 0.
REQ-027 SHALL, without the macro, omit ovf_clr and sticky_ovf entirely; all other behaviour is identical.

Verification
REQ-028 SHALL cover ADD (aluop 010) in_result=0x8000, a_msb=0, b_msb=0, c_last=0 -> next cycle out_valid=1, neg=1, ovf=1, zero=0, carry=0.
REQ-029 SHALL cover SUB (aluop 110) 5-5: in_result=0x0000, a_msb=0, b_msb=1, c_last=1 -> zero=1, carry=1, ovf=0, neg=0.
REQ-030 SHALL cover AND (aluop 000) in_result=0x0000, c_last=1 -> zero=1, carry=0, ovf=0.
REQ-031 SHALL cover out_ready=0 with three back-to-back beats 0x0001, 0x0002, 0x0003 -> two accepted, in_ready=0 on third; out_ready=1 -> 0x0001, 0x0002, then 0x0003, in order, none lost.
REQ-032 SHALL cover rst_n pulsed low with 2 beats buffered -> out_valid=0 immediately (asynchronous), no stale beat after release, in_ready=1 after first edge.
REQ-033 SHALL cover, with ALU_FLAGS_STICKY_OVF_EN, an ovf=1 beat then ovf=0 beat -> sticky_ovf stays 1; ovf_clr=1 for one cycle -> 0.

Source files
------------

// File: rtl/alu_flags_stage.sv
// Flag-generation stage behind a 16-bit CLA ALU: captures zero/neg/carry/ovf and buffers beats in a 2-entry FIFO.
// Optional sticky-overflow tracking is compiled in with `define ALU_FLAGS_STICKY_OVF_EN.
module alu_flags_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_result,
   input  logic        in_c_last,
   input  logic        in_a_msb,
   input  logic        in_b_msb,
   input  logic [2:0]  in_aluop,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] out_result,
   output logic        out_zero,
   output logic        out_neg,
   output logic        out_carry,
   output logic        out_ovf
`ifdef ALU_FLAGS_STICKY_OVF_EN
   ,
   input  logic        ovf_clr,
   output logic        sticky_ovf
`endif
);

   typedef struct packed {
      logic [15:0] result;
      logic        zero;
      logic        neg;
      logic        carry;
      logic        ovf;
   } beat_t;

   beat_t      r_head;
   beat_t      r_tail;
   logic [1:0] r_count;
   logic       r_live;

   beat_t      w_beat;
   logic       w_arith;
   logic       w_push;
   logic       w_pop;

   // Only add (010) and sub (110) produce meaningful carry/overflow.
   always_comb begin
      w_arith       = (in_aluop[1:0] == 2'b10);
      w_beat        = '0;
      w_beat.result = in_result;
      w_beat.zero   = (in_result == 16'h0000);
      w_beat.neg    = in_result[15];
      w_beat.carry  = w_arith && in_c_last;
      w_beat.ovf    = w_arith && (in_a_msb == in_b_msb) && (in_result[15] != in_a_msb);
   end

   // r_live keeps in_ready low until the first edge after reset release.
   assign in_ready  = r_live && (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the slots are reset, not just the count, because the outputs are read straight from r_head.
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
         r_live  <= 1'b0;
      end else begin
         r_live <= 1'b1;
         case (r_count)
            2'd0: begin
               if (w_push) begin
                  r_head  <= w_beat;
                  r_count <= 2'd1;
               end
            end
            2'd1: begin
               case ({w_push, w_pop})
                  2'b10: begin
                     r_tail  <= w_beat;
                     r_count <= 2'd2;
                  end
                  2'b01: r_count <= 2'd0;
                  2'b11: r_head  <= w_beat;
                  default: ;
               endcase
            end
            2'd2: begin
               // Full: in_ready is low, so only a release can happen.
               if (w_pop) begin
                  r_head  <= r_tail;
                  r_count <= 2'd1;
               end
            end
            default: r_count <= 2'd0;
         endcase
      end
   end

   assign out_result = r_head.result;
   assign out_zero   = r_head.zero;
   assign out_neg    = r_head.neg;
   assign out_carry  = r_head.carry;
   assign out_ovf    = r_head.ovf;

`ifdef ALU_FLAGS_STICKY_OVF_EN
   logic r_sticky_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky_ovf <= 1'b0;
      end else if (ovf_clr) begin
         r_sticky_ovf <= 1'b0;
      end else if (w_pop && r_head.ovf) begin
         r_sticky_ovf <= 1'b1;
      end
   end

   assign sticky_ovf = r_sticky_ovf;
`endif

endmodule

// File: tb/tb_alu_flags_stage.sv
// Scoreboard bench for alu_flags_stage: driver pushes expected beats on acceptance, a negedge monitor pops and compares.
// Expected flags for random add/sub come from signed/unsigned operand arithmetic, not from the slice signals.
module tb_alu_flags_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic        in_c_last;
   logic        in_a_msb;
   logic        in_b_msb;
   logic [2:0]  in_aluop;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_result;
   logic        out_zero;
   logic        out_neg;
   logic        out_carry;
   logic        out_ovf;
`ifdef ALU_FLAGS_STICKY_OVF_EN
   logic        ovf_clr;
   logic        sticky_ovf;
`endif

   typedef struct {
      logic [15:0] r;
      logic        z;
      logic        n;
      logic        c;
      logic        o;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   ready_mode = 0;  // 0: hold low, 1: hold high, 2: random

   alu_flags_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_c_last  (in_c_last),
      .in_a_msb   (in_a_msb),
      .in_b_msb   (in_b_msb),
      .in_aluop   (in_aluop),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_carry  (out_carry),
      .out_ovf    (out_ovf)
`ifdef ALU_FLAGS_STICKY_OVF_EN
      ,
      .ovf_clr    (ovf_clr),
      .sticky_ovf (sticky_ovf)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always begin
      @(posedge clk);
      #2;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: pops on each output handshake, and checks outputs hold while stalled.
   logic        stall;
   logic [15:0] h_r;
   logic        h_z, h_n, h_c, h_o;
   initial stall = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("hold_result", out_result, h_r);
            check("hold_flags", {out_zero, out_neg, out_carry, out_ovf}, {h_z, h_n, h_c, h_o});
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_beat", out_result, 32'hDEAD_BEEF);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("out_result", out_result, e.r);
               check("out_zero", out_zero, e.z);
               check("out_neg", out_neg, e.n);
               check("out_carry", out_carry, e.c);
               check("out_ovf", out_ovf, e.o);
            end
         end
         stall = out_valid && !out_ready;
         h_r = out_result;
         h_z = out_zero;
         h_n = out_neg;
         h_c = out_carry;
         h_o = out_ovf;
      end
   end

   task automatic garbage_inputs();
      in_result = 16'($urandom);
      in_c_last = 1'($urandom);
      in_a_msb  = 1'($urandom);
      in_b_msb  = 1'($urandom);
      in_aluop  = 3'($urandom);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [15:0] res, input logic c, input logic a, input logic b,
                       input logic [2:0] op, input exp_t e);
      int n = 0;
      in_valid  = 1'b1;
      in_result = res;
      in_c_last = c;
      in_a_msb  = a;
      in_b_msb  = b;
      in_aluop  = op;
      while (!in_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
      end else begin
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      garbage_inputs();
   endtask

   task automatic drain();
      int n = 0;
      ready_mode = 1;
      while ((q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_done", {q.size() == 0, out_valid}, 2'b10);
   endtask

   function automatic exp_t mk(input logic [15:0] r, input logic z, input logic n,
                                input logic c, input logic o);
      exp_t e;
      e.r = r; e.z = z; e.n = n; e.c = c; e.o = o;
      return e;
   endfunction

   // Random beat: real operands for add/sub so flags follow from integer arithmetic.
   task automatic send_random();
      logic [2:0]  op;
      logic [15:0] a, b, b_eff, res;
      logic [16:0] sum;
      logic        sub;
      int          sres;
      exp_t        e;
      op = 3'($urandom);
      if (op[1:0] == 2'b10) begin
         a     = 16'($urandom);
         b     = 16'($urandom);
         if ($urandom_range(0, 7) == 0) b = a;
         sub   = op[2];
         b_eff = sub ? ~b : b;
         sum   = {1'b0, a} + {1'b0, b_eff} + {16'h0, sub};
         res   = sum[15:0];
         sres  = sub ? ($signed(a) - $signed(b)) : ($signed(a) + $signed(b));
         e.r   = res;
         e.z   = (res == 16'h0);
         e.n   = res[15];
         e.c   = sub ? (a >= b) : ((32'(a) + 32'(b)) > 65535);
         e.o   = (sres > 32767) || (sres < -32768);
         send(res, sum[16], a[15], b_eff[15], op, e);
      end else begin
         res = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
         e   = mk(res, res == 16'h0, res[15], 1'b0, 1'b0);
         send(res, 1'($urandom), 1'($urandom), 1'($urandom), op, e);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      garbage_inputs();
`ifdef ALU_FLAGS_STICKY_OVF_EN
      ovf_clr = 1'b0;
`endif
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_outputs", {out_result, out_zero, out_neg, out_carry, out_ovf}, 0);
`ifdef ALU_FLAGS_STICKY_OVF_EN
      check("rst_sticky", sticky_ovf, 0);
`endif
      #10 rst_n = 1'b1;
      #1;
      check("in_ready_before_edge", in_ready, 0);
      @(posedge clk);
      #1;
      check("in_ready_after_edge", in_ready, 1);

      // ADD overflow into the sign bit, with latency-1 visibility.
      ready_mode = 0;
      @(posedge clk);
      #1;
      send(16'h8000, 1'b0, 1'b0, 1'b0, 3'b010, mk(16'h8000, 0, 1, 0, 1));
      check("latency1_valid", out_valid, 1);
      drain();

      // SUB 5-5 and AND with stray carry.
      send(16'h0000, 1'b1, 1'b0, 1'b1, 3'b110, mk(16'h0000, 1, 0, 1, 0));
      send(16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, mk(16'h0000, 1, 0, 0, 0));
      drain();

      // Back-pressure: two beats fit, the third waits.
      ready_mode = 0;
      @(posedge clk);
      #1;
      send(16'h0001, 1'b0, 1'b0, 1'b0, 3'b000, mk(16'h0001, 0, 0, 0, 0));
      send(16'h0002, 1'b0, 1'b0, 1'b0, 3'b000, mk(16'h0002, 0, 0, 0, 0));
      in_valid  = 1'b1;
      in_result = 16'h0003;
      check("full_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      check("full_in_ready_held", in_ready, 0);
      ready_mode = 1;
      #2;
      check("full_pop_in_ready", in_ready, 0);
      send(16'h0003, 1'b0, 1'b0, 1'b0, 3'b000, mk(16'h0003, 0, 0, 0, 0));
      drain();

      // Asynchronous reset with two beats buffered.
      ready_mode = 0;
      @(posedge clk);
      #1;
      send(16'h1234, 1'b0, 1'b0, 1'b0, 3'b001, mk(16'h1234, 0, 0, 0, 0));
      send(16'h5678, 1'b0, 1'b0, 1'b0, 3'b001, mk(16'h5678, 0, 0, 0, 0));
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_in_ready", in_ready, 0);
      check("async_rst_result", out_result, 0);
      q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("rel_in_ready_before_edge", in_ready, 0);
      @(posedge clk);
      #1;
      check("rel_in_ready", in_ready, 1);
      check("rel_out_valid", out_valid, 0);
      ready_mode = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("no_stale_beat", out_valid, 0);
      end

`ifdef ALU_FLAGS_STICKY_OVF_EN
      send(16'h8000, 1'b0, 1'b0, 1'b0, 3'b010, mk(16'h8000, 0, 1, 0, 1));
      send(16'h0001, 1'b0, 1'b0, 1'b0, 3'b010, mk(16'h0001, 0, 0, 0, 0));
      drain();
      check("sticky_set", sticky_ovf, 1);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      check("sticky_clr", sticky_ovf, 0);
`endif

      // Randomized traffic with random back-pressure and idle gaps.
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            garbage_inputs();
            @(posedge clk);
            #1;
         end
         send_random();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
